ap_ctrl_multi_monitor: RTL and testbench
========================================

Name: ap_ctrl_multi_monitor

Overview:
- Synthesizable, parametrised successor to the per-module ap_ctrl status monitors used in the dataflow testbench.
- Watches NUM_CH independent ap_start/ap_ready/ap_done/ap_continue handshakes, one per HLS module instance.
- Keeps saturating per-channel counters and freezes them when `finish` asserts.
- Exposes all counters through a registered read port, so the bench and on-chip debug logic can sample activity without file-dump classes.

Parameters:
- NUM_CH, 4: number of monitored handshake channels (1..32).
- CNT_W, 32: width of the event and cycle counters.
- LAT_W, 16: width of the latency registers. Used only with LATENCY_TRACK_EN.

Ports:
- clock, in, 1: sole clock; all logic is on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- finish, in, 1: end-of-simulation/run indicator; freezes all counters (sticky).
- ap_start, in, NUM_CH: per-channel ap_start.
- ap_ready, in, NUM_CH: per-channel ap_ready.
- ap_done, in, NUM_CH: per-channel ap_done.
- ap_continue, in, NUM_CH: per-channel ap_continue; tie to 1 for modules without continue.
- rd_req, in, 1: read strobe.
- rd_ch, in, $clog2(NUM_CH) (min 1): channel to read.
- rd_field, in, 3: counter select.
- rd_valid, out, 1: rd_data is valid this cycle.
- rd_data, out, CNT_W: selected counter, zero-extended.
- frozen, out, 1: sticky copy of finish.
- all_idle, out, 1: every channel is in IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - All counters, FSMs, rd_valid, rd_data and frozen go to 0; all_idle goes to 1.
  - Reset overrides every other input in the same cycle, including reset during ACTIVE or DONE_WAIT. The next cycle starts clean.
- Per-channel FSM, states IDLE, ACTIVE, DONE_WAIT:
  - IDLE -> ACTIVE when ap_start=1 and frozen=0.
  - ACTIVE, ap_done=1 and ap_continue=1:
    - go to IDLE when ap_start=0;
    - stay in ACTIVE when ap_start=1 (back-to-back transaction; latency restarts).
  - ACTIVE -> DONE_WAIT when ap_done=1 and ap_continue=0.
  - DONE_WAIT -> IDLE when ap_continue=1, or -> ACTIVE when ap_start=1 in that same cycle.
- Counters per channel; all saturate at all-ones and never wrap:
  - field 0, starts: +1 on every cycle with ap_start & ap_ready. Pipelined overlap is counted even in ACTIVE.
  - field 1, dones: +1 on an accepted completion, i.e. ap_done & ap_continue in ACTIVE, or ap_continue in DONE_WAIT.
  - field 2, busy cycles: +1 each cycle in ACTIVE.
  - field 3, stall cycles: +1 each cycle in DONE_WAIT.
  - fields 4-7: read 0 without the optional feature.
- Freeze:
  - The first cycle in which finish=1 sets frozen at the next edge.
  - From that edge on, no counter or FSM state changes until reset.
  - Events in the cycle where finish first asserts are still counted.
- Read port:
  - rd_req in cycle N gives rd_valid=1 and rd_data in cycle N+1 (1-cycle latency), one read per cycle, fully pipelined.
  - rd_data shows the counter value as it stood at the end of cycle N; updates made in cycle N are not visible.
  - rd_ch >= NUM_CH returns 0 with rd_valid=1.
  - rd_valid=0 in every cycle not preceded by rd_req; rd_data holds its last value.
- all_idle is registered: it reflects FSM states after the current edge.

Optional Feature:
- Macro: AP_MON_LATENCY_TRACK_EN.
- When defined:
  - Each channel has a LAT_W latency timer. It loads 1 on the IDLE->ACTIVE transition, or on a back-to-back restart, and increments in ACTIVE.
  - On ap_done in ACTIVE, the timer value updates max_lat (field 4) and min_lat (field 5).
  - min_lat resets to all-ones and reads all-ones until the first done.
  - The timer saturates at all-ones.
  - Both fields are zero-extended to CNT_W.
- When undefined: no latency registers exist; fields 4 and 5 read 0.

Decomposition:
- Package ap_mon_pkg holds:
  - the state enum type ap_mon_state_t;
  - field code localparams FLD_STARTS=0, FLD_DONES=1, FLD_BUSY=2, FLD_STALL=3, FLD_MAXLAT=4, FLD_MINLAT=5;
  - a parametrised saturating-increment function.
- Sub-module ap_mon_channel holds one FSM plus its counters and is instantiated NUM_CH times in a generate loop.
- The top level does only the freeze register, the read multiplexer and the all_idle reduction.

Test Plan:
1. Reset, then read each of fields 0-3 on ch0 -> rd_valid one cycle after rd_req, rd_data=0, all_idle=1, frozen=0.
2. ch1: start+ready for 1 cycle, ACTIVE for 5 cycles, done+continue -> starts=1, dones=1, busy=6, stall=0; with the macro, max_lat=min_lat=6.
3. ch2: done with continue=0 held for 3 cycles, then continue=1 -> stall=3, dones=1, FSM back in IDLE, all_idle=1.
4. ch0: back-to-back done+continue+start for 4 transactions of 3 cycles each -> dones=4, starts=4, busy=12, ch0 never IDLE between transactions.
5. CNT_W=4 and ch3 held ACTIVE for 20 cycles -> busy reads 15 (saturated); finish then pulses once -> frozen=1 and further activity leaves all fields unchanged; reset mid-ACTIVE clears everything next cycle.
6. NUM_CH=3, rd_ch=3 -> rd_valid=1, rd_data=0; back-to-back reads on consecutive cycles each return their own field.

Source files
------------

// File: rtl/ap_mon_pkg.sv
// -----------------------------------------------------------------------------
// ap_mon_pkg
// Shared types and helpers for the ap_ctrl multi-channel handshake monitor.
//   ap_mon_state_t : per-channel handshake FSM state
//   FLD_*          : read-port field codes (rd_field)
//   ch_idx_w()     : width of the channel-select index (at least 1 bit)
//   sat_inc()      : saturating increment for counters up to 64 bits wide
// Optional feature macro used by the design: AP_MON_LATENCY_TRACK_EN
// -----------------------------------------------------------------------------
package ap_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_DONE_WAIT = 2'd2
    } ap_mon_state_t;

    localparam logic [2:0] FLD_STARTS = 3'd0;
    localparam logic [2:0] FLD_DONES  = 3'd1;
    localparam logic [2:0] FLD_BUSY   = 3'd2;
    localparam logic [2:0] FLD_STALL  = 3'd3;
    localparam logic [2:0] FLD_MAXLAT = 3'd4;
    localparam logic [2:0] FLD_MINLAT = 3'd5;

    // Number of selectable fields on the read port (3-bit field code).
    localparam int NUM_FLD = 8;

    // A single channel still needs a 1-bit select so the port never collapses.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Increment v, clamping at the all-ones value of a w-bit counter.
    // Callers cast the result back to their own width.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? max_v : (v + 64'd1);
    endfunction

endpackage

// File: rtl/ap_mon_channel.sv
// -----------------------------------------------------------------------------
// ap_mon_channel
// One ap_ctrl handshake monitor: IDLE/ACTIVE/DONE_WAIT FSM plus saturating
// start / done / busy / stall counters. With AP_MON_LATENCY_TRACK_EN defined
// it also times each transaction and keeps the max and min latency seen.
// Ports:
//   clock_i, reset_i : clock, synchronous active-high reset
//   freeze_i         : when high, all state holds (counters and FSM)
//   ap_start_i, ap_ready_i, ap_done_i, ap_continue_i : watched handshake
//   idle_o           : FSM currently in IDLE
//   fld_o            : all read fields, indexed by FLD_* codes, CNT_W wide
// -----------------------------------------------------------------------------
module ap_mon_channel
    import ap_mon_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int LAT_W = 16
) (
    input  logic                            clock_i,
    input  logic                            reset_i,
    input  logic                            freeze_i,
    input  logic                            ap_start_i,
    input  logic                            ap_ready_i,
    input  logic                            ap_done_i,
    input  logic                            ap_continue_i,
    output logic                            idle_o,
    output logic [NUM_FLD-1:0][CNT_W-1:0]   fld_o
);

    ap_mon_state_t     state_q, state_d;
    logic [CNT_W-1:0]  starts_q, starts_d;
    logic [CNT_W-1:0]  dones_q, dones_d;
    logic [CNT_W-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    // accept: a completion is consumed this cycle.
    // enter : ACTIVE is (re)entered this cycle, so a new transaction begins.
    logic accept;
    logic enter;

    always_comb begin
        state_d  = state_q;
        starts_d = starts_q;
        dones_d  = dones_q;
        busy_d   = busy_q;
        stall_d  = stall_q;
        accept   = 1'b0;
        enter    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ap_start_i) begin
                    state_d = ST_ACTIVE;
                    enter   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ap_done_i) begin
                    if (ap_continue_i) begin
                        accept = 1'b1;
                        // A start alongside the accepted done is a
                        // back-to-back transaction: stay ACTIVE.
                        if (ap_start_i) begin
                            enter = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_DONE_WAIT;
                    end
                end
            end
            ST_DONE_WAIT: begin
                if (ap_continue_i) begin
                    accept = 1'b1;
                    if (ap_start_i) begin
                        state_d = ST_ACTIVE;
                        enter   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Starts are counted in any state so pipelined overlap is visible.
        if (ap_start_i && ap_ready_i) begin
            starts_d = CNT_W'(sat_inc(64'(starts_q), CNT_W));
        end
        if (accept) begin
            dones_d = CNT_W'(sat_inc(64'(dones_q), CNT_W));
        end
        if (state_q == ST_ACTIVE) begin
            busy_d = CNT_W'(sat_inc(64'(busy_q), CNT_W));
        end
        if (state_q == ST_DONE_WAIT) begin
            stall_d = CNT_W'(sat_inc(64'(stall_q), CNT_W));
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            starts_q <= '0;
            dones_q  <= '0;
            busy_q   <= '0;
            stall_q  <= '0;
        end else if (!freeze_i) begin
            state_q  <= state_d;
            starts_q <= starts_d;
            dones_q  <= dones_d;
            busy_q   <= busy_d;
            stall_q  <= stall_d;
        end
    end

`ifdef AP_MON_LATENCY_TRACK_EN
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [LAT_W-1:0] max_lat_q, max_lat_d;
    logic [LAT_W-1:0] min_lat_q, min_lat_d;

    always_comb begin
        lat_d     = lat_q;
        max_lat_d = max_lat_q;
        min_lat_d = min_lat_q;

        // The first ACTIVE cycle counts as 1; a restart takes priority
        // over the running increment.
        if (enter) begin
            lat_d = LAT_W'(1);
        end else if (state_q == ST_ACTIVE) begin
            lat_d = LAT_W'(sat_inc(64'(lat_q), LAT_W));
        end

        if ((state_q == ST_ACTIVE) && ap_done_i) begin
            if (lat_q > max_lat_q) begin
                max_lat_d = lat_q;
            end
            if (lat_q < min_lat_q) begin
                min_lat_d = lat_q;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            lat_q     <= '0;
            max_lat_q <= '0;
            min_lat_q <= '1;
        end else if (!freeze_i) begin
            lat_q     <= lat_d;
            max_lat_q <= max_lat_d;
            min_lat_q <= min_lat_d;
        end
    end
`endif

    assign idle_o = (state_q == ST_IDLE);

    always_comb begin
        fld_o             = '0;
        fld_o[FLD_STARTS] = starts_q;
        fld_o[FLD_DONES]  = dones_q;
        fld_o[FLD_BUSY]   = busy_q;
        fld_o[FLD_STALL]  = stall_q;
`ifdef AP_MON_LATENCY_TRACK_EN
        fld_o[FLD_MAXLAT] = CNT_W'(max_lat_q);
        fld_o[FLD_MINLAT] = CNT_W'(min_lat_q);
`else
        // No latency registers exist: the latency fields are constant zero.
        fld_o[FLD_MAXLAT] = CNT_W'({LAT_W{1'b0}});
        fld_o[FLD_MINLAT] = CNT_W'({LAT_W{1'b0}});
`endif
    end

endmodule

// File: rtl/ap_ctrl_multi_monitor.sv
// -----------------------------------------------------------------------------
// ap_ctrl_multi_monitor
// Watches NUM_CH ap_ctrl handshakes (one ap_mon_channel each), freezes all
// counters once finish is seen, and exposes every counter through a
// registered, fully pipelined read port.
// Optional feature macro: AP_MON_LATENCY_TRACK_EN (adds max/min latency,
// fields 4 and 5; without it those fields read 0).
// Ports:
//   clock, reset  : clock, synchronous active-high reset
//   finish        : freezes all counters and FSMs from the next edge (sticky)
//   ap_start, ap_ready, ap_done, ap_continue : per-channel handshakes
//   rd_req, rd_ch, rd_field : read request, channel and field select
//   rd_valid, rd_data       : read response one cycle after rd_req
//   frozen        : sticky copy of finish
//   all_idle      : every channel FSM is in IDLE
// -----------------------------------------------------------------------------
module ap_ctrl_multi_monitor
    import ap_mon_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int LAT_W  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          finish,
    input  logic [NUM_CH-1:0]             ap_start,
    input  logic [NUM_CH-1:0]             ap_ready,
    input  logic [NUM_CH-1:0]             ap_done,
    input  logic [NUM_CH-1:0]             ap_continue,
    input  logic                          rd_req,
    input  logic [ch_idx_w(NUM_CH)-1:0]   rd_ch,
    input  logic [2:0]                    rd_field,
    output logic                          rd_valid,
    output logic [CNT_W-1:0]              rd_data,
    output logic                          frozen,
    output logic                          all_idle
);

    localparam int CH_W     = ch_idx_w(NUM_CH);
    // Every encodable rd_ch value gets a slot; unused slots read zero, which
    // makes out-of-range channels return 0 without a separate compare.
    localparam int CH_SLOTS = 1 << CH_W;

    logic                                frozen_q;
    logic                                rd_valid_q;
    logic [CNT_W-1:0]                    rd_data_q, rd_data_d;
    logic [NUM_FLD-1:0][CNT_W-1:0]       fld_slot [CH_SLOTS];
    logic [NUM_CH-1:0]                   idle_ch;

    genvar gi;
    generate
        for (gi = 0; gi < CH_SLOTS; gi++) begin : g_slot
            if (gi < NUM_CH) begin : g_live
                ap_mon_channel #(
                    .CNT_W (CNT_W),
                    .LAT_W (LAT_W)
                ) u_ch (
                    .clock_i       (clock),
                    .reset_i       (reset),
                    .freeze_i      (frozen_q),
                    .ap_start_i    (ap_start[gi]),
                    .ap_ready_i    (ap_ready[gi]),
                    .ap_done_i     (ap_done[gi]),
                    .ap_continue_i (ap_continue[gi]),
                    .idle_o        (idle_ch[gi]),
                    .fld_o         (fld_slot[gi])
                );
            end else begin : g_pad
                assign fld_slot[gi] = '0;
            end
        end
    endgenerate

    // Select from the current register values, so a read sees counters as
    // they stood before this cycle's updates land.
    assign rd_data_d = fld_slot[rd_ch][rd_field];

    always_ff @(posedge clock) begin
        if (reset) begin
            frozen_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            if (finish) begin
                frozen_q <= 1'b1;
            end
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign frozen   = frozen_q;
    // Built from the state registers only, so it tracks the post-edge states.
    assign all_idle = &idle_ch;

endmodule

// File: tb/tb_ap_ctrl_multi_monitor.sv
// -----------------------------------------------------------------------------
// tb_ap_ctrl_multi_monitor
// Directed bench for ap_ctrl_multi_monitor. Three instances share one set of
// stimulus: dut_a (4 ch, 32-bit), dut_s (4 ch, 4-bit counters, saturation)
// and dut_c (3 ch, out-of-range channel reads).
// Latency fields are checked against AP_MON_LATENCY_TRACK_EN when defined.
// -----------------------------------------------------------------------------
module tb_ap_ctrl_multi_monitor;

`ifdef AP_MON_LATENCY_TRACK_EN
    localparam bit LAT_EN = 1'b1;
`else
    localparam bit LAT_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        finish;
    logic [3:0]  ap_start, ap_ready, ap_done, ap_continue;
    logic        rd_req;
    logic [1:0]  rd_ch;
    logic [2:0]  rd_field;

    logic        a_rd_valid, a_frozen, a_all_idle;
    logic [31:0] a_rd_data;
    logic        s_rd_valid, s_frozen, s_all_idle;
    logic [3:0]  s_rd_data;
    logic        c_rd_valid, c_frozen, c_all_idle;
    logic [31:0] c_rd_data;

    int n_pass  = 0;
    int n_total = 0;

    ap_ctrl_multi_monitor #(.NUM_CH(4), .CNT_W(32), .LAT_W(16)) dut_a (
        .clock(clock), .reset(reset), .finish(finish),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .rd_req(rd_req), .rd_ch(rd_ch),
        .rd_field(rd_field), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
        .frozen(a_frozen), .all_idle(a_all_idle)
    );

    ap_ctrl_multi_monitor #(.NUM_CH(4), .CNT_W(4), .LAT_W(4)) dut_s (
        .clock(clock), .reset(reset), .finish(finish),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .rd_req(rd_req), .rd_ch(rd_ch),
        .rd_field(rd_field), .rd_valid(s_rd_valid), .rd_data(s_rd_data),
        .frozen(s_frozen), .all_idle(s_all_idle)
    );

    ap_ctrl_multi_monitor #(.NUM_CH(3), .CNT_W(32), .LAT_W(16)) dut_c (
        .clock(clock), .reset(reset), .finish(finish),
        .ap_start(ap_start[2:0]), .ap_ready(ap_ready[2:0]), .ap_done(ap_done[2:0]),
        .ap_continue(ap_continue[2:0]), .rd_req(rd_req), .rd_ch(rd_ch),
        .rd_field(rd_field), .rd_valid(c_rd_valid), .rd_data(c_rd_data),
        .frozen(c_frozen), .all_idle(c_all_idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input logic [31:0] got, input logic [31:0] exp, input string tag);
        n_total++;
        assert (got === exp) begin
            n_pass++;
            $display("check %s got=%0h exp=%0h ok", tag, got, exp);
        end else begin
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Single read on dut_a: request, one edge, then check valid and data.
    task automatic rd_a(input logic [1:0] ch, input logic [2:0] f,
                        input logic [31:0] exp, input string tag);
        rd_req   = 1'b1;
        rd_ch    = ch;
        rd_field = f;
        tick();
        rd_req = 1'b0;
        check(32'(a_rd_valid), 32'd1, {tag, "_vld"});
        check(a_rd_data, exp, tag);
    endtask

    initial begin
        reset = 1'b1; finish = 1'b0;
        ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = 4'hF;
        rd_req = 1'b0; rd_ch = '0; rd_field = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1. reset state
        check(32'(a_rd_valid), 32'd0, "rst_vld");
        check(a_rd_data, 32'd0, "rst_data");
        check(32'(a_frozen), 32'd0, "rst_frozen");
        check(32'(a_all_idle), 32'd1, "rst_idle");
        for (int f = 0; f < 4; f++) begin
            rd_a(2'd0, 3'(f), 32'd0, $sformatf("rst_ch0_f%0d", f));
        end
        tick();
        check(32'(a_rd_valid), 32'd0, "vld_drop");

        // 2. ch1 single transaction: 1 start cycle, 5 ACTIVE, done+continue
        ap_start[1] = 1'b1; ap_ready[1] = 1'b1;
        tick();
        ap_start[1] = 1'b0; ap_ready[1] = 1'b0;
        check(32'(a_all_idle), 32'd0, "ch1_busy_idle");
        for (int i = 0; i < 5; i++) tick();
        ap_done[1] = 1'b1;
        tick();
        ap_done[1] = 1'b0;
        check(32'(a_all_idle), 32'd1, "ch1_back_idle");
        rd_a(2'd1, 3'd0, 32'd1, "ch1_starts");
        rd_a(2'd1, 3'd1, 32'd1, "ch1_dones");
        rd_a(2'd1, 3'd2, 32'd6, "ch1_busy");
        rd_a(2'd1, 3'd3, 32'd0, "ch1_stall");
        rd_a(2'd1, 3'd4, LAT_EN ? 32'd6 : 32'd0, "ch1_maxlat");
        rd_a(2'd1, 3'd5, LAT_EN ? 32'd6 : 32'd0, "ch1_minlat");
        rd_a(2'd1, 3'd7, 32'd0, "ch1_f7");

        // 3. ch2 completion stalled by continue=0 for 3 cycles
        ap_start[2] = 1'b1; ap_ready[2] = 1'b1;
        tick();
        ap_start[2] = 1'b0; ap_ready[2] = 1'b0;
        ap_done[2] = 1'b1; ap_continue[2] = 1'b0;
        tick();
        ap_done[2] = 1'b0;
        tick();
        tick();
        check(32'(a_all_idle), 32'd0, "ch2_dw_idle");
        ap_continue[2] = 1'b1;
        tick();
        check(32'(a_all_idle), 32'd1, "ch2_back_idle");
        rd_a(2'd2, 3'd3, 32'd3, "ch2_stall");
        rd_a(2'd2, 3'd1, 32'd1, "ch2_dones");
        rd_a(2'd2, 3'd2, 32'd1, "ch2_busy");

        // 4. ch0 four back-to-back transactions of 3 ACTIVE cycles each
        ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
        tick();
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            tick();
            check(32'(a_all_idle), 32'd0, $sformatf("b2b_t%0d_mid", t));
            ap_done[0]  = 1'b1;
            ap_start[0] = (t < 3);
            ap_ready[0] = (t < 3);
            tick();
            ap_done[0] = 1'b0; ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
            check(32'(a_all_idle), (t == 3) ? 32'd1 : 32'd0, $sformatf("b2b_t%0d_end", t));
        end
        rd_a(2'd0, 3'd0, 32'd4, "b2b_starts");
        rd_a(2'd0, 3'd1, 32'd4, "b2b_dones");
        rd_a(2'd0, 3'd2, 32'd12, "b2b_busy");
        rd_a(2'd0, 3'd3, 32'd0, "b2b_stall");
        rd_a(2'd0, 3'd4, LAT_EN ? 32'd3 : 32'd0, "b2b_maxlat");

        // 5. saturation on 4-bit counters, freeze, reset mid-ACTIVE
        ap_start[3] = 1'b1; ap_ready[3] = 1'b1;
        tick();
        ap_start[3] = 1'b0; ap_ready[3] = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        rd_req = 1'b1; rd_ch = 2'd3; rd_field = 3'd2;
        tick();
        rd_req = 1'b0;
        check(32'(s_rd_data), 32'd15, "sat_busy_s");
        check(a_rd_data, 32'd20, "busy20_a");
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check(32'(a_frozen), 32'd1, "frozen_set");
        ap_start[1] = 1'b1; ap_ready[1] = 1'b1; ap_done[3] = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        ap_start[1] = 1'b0; ap_ready[1] = 1'b0; ap_done[3] = 1'b0;
        check(32'(a_frozen), 32'd1, "frozen_sticky");
        check(32'(a_all_idle), 32'd0, "frozen_ch3_active");
        rd_a(2'd3, 3'd2, 32'd22, "frz_busy");
        rd_a(2'd3, 3'd1, 32'd0, "frz_dones");
        rd_a(2'd1, 3'd0, 32'd1, "frz_ch1_starts");
        reset = 1'b1; ap_start[3] = 1'b1; ap_ready[3] = 1'b1;
        tick();
        reset = 1'b0; ap_start[3] = 1'b0; ap_ready[3] = 1'b0;
        check(32'(a_frozen), 32'd0, "rst2_frozen");
        check(32'(a_all_idle), 32'd1, "rst2_idle");
        check(32'(a_rd_valid), 32'd0, "rst2_vld");
        check(a_rd_data, 32'd0, "rst2_data");
        rd_a(2'd3, 3'd2, 32'd0, "rst2_busy");
        rd_a(2'd3, 3'd0, 32'd0, "rst2_starts");

        // 6. 3-channel instance: pipelined reads and out-of-range channel
        ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
        tick();
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
        tick();
        ap_done[0] = 1'b1;
        tick();
        ap_done[0] = 1'b0;
        rd_req = 1'b1; rd_ch = 2'd0; rd_field = 3'd0;
        tick();
        check(c_rd_data, 32'd1, "c_pipe_starts");
        rd_field = 3'd1;
        tick();
        check(c_rd_data, 32'd1, "c_pipe_dones");
        rd_field = 3'd2;
        tick();
        check(32'(c_rd_valid), 32'd1, "c_pipe_vld");
        check(c_rd_data, 32'd2, "c_pipe_busy");
        rd_req = 1'b0;
        tick();
        check(32'(c_rd_valid), 32'd0, "c_idle_vld");
        check(c_rd_data, 32'd2, "c_hold_data");
        rd_req = 1'b1; rd_ch = 2'd3; rd_field = 3'd2;
        tick();
        rd_req = 1'b0;
        check(32'(c_rd_valid), 32'd1, "c_oor_vld");
        check(c_rd_data, 32'd0, "c_oor_data");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
